// File: rtl/cpu_pkg.sv
// Shared constants and state encoding for the core, the instruction store and its bench.
package cpu_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   localparam logic [DATA_W-1:0] NOP_INST = 8'h00;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } store_state_t;

endpackage

// File: rtl/instruction_store_if.sv
// Core fetch port plus byte-wide program load port of the instruction store.
interface instruction_store_if;
   import cpu_pkg::*;

   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] instruction;
   logic              cpu_hold;
   logic              load_start;
   logic [ADDR_W-1:0] load_len;
   logic [DATA_W-1:0] load_data;
   logic              load_valid;
   logic              load_ready;
   logic              load_done;

   modport master (
      output pc, load_start, load_len, load_data, load_valid,
      input  instruction, cpu_hold, load_ready, load_done
   );

   modport slave (
      input  pc, load_start, load_len, load_data, load_valid,
      output instruction, cpu_hold, load_ready, load_done
   );

endinterface

// File: rtl/inst_ram.sv
// Single-port instruction RAM; read data registered, 1-cycle latency.
// No backpressure: a write or read is performed on every edge.
module inst_ram
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   // Contents survive reset so a partial load is retained.
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/instruction_store.sv
// Program store for the 8-bit core: loads bytes, then serves mem[pc] with 1-cycle latency.
// Backpressure: load_ready only in LOAD; cpu_hold stalls the core until a full load completes.
module instruction_store
   import cpu_pkg::*;
(
   input  logic              origclk,
   input  logic              reset,
   instruction_store_if.slave bus
);

   store_state_t      state_q;
   store_state_t      state_d;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [ADDR_W-1:0] len_q;
   logic              load_done_q;
   logic              fetch_vld_q;

   logic              xfer;
   logic              last_xfer;
   logic              start;
   logic              fetch_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_rdata;

   assign xfer      = (state_q == LOAD) && bus.load_valid;
   assign last_xfer = xfer && (wr_addr_q == len_q);
   // A start request while already loading is dropped.
   assign start     = (state_q != LOAD) && bus.load_start;

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (start)     state_d = LOAD;
         LOAD:    if (last_xfer) state_d = RUN;
         RUN:     if (start)     state_d = LOAD;
         default:                state_d = EMPTY;
      endcase
   end

   // Fetch only on edges that stay in RUN, so leaving RUN shows NOP immediately.
   assign fetch_en = (state_q == RUN) && (state_d == RUN);

   always_ff @(posedge origclk or negedge reset) begin
      if (!reset) begin
         state_q     <= EMPTY;
         wr_addr_q   <= '0;
         len_q       <= '0;
         load_done_q <= 1'b0;
         fetch_vld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_done_q <= last_xfer;
         fetch_vld_q <= fetch_en;
         if (start) begin
            len_q     <= bus.load_len;
            wr_addr_q <= '0;
         end else if (xfer && !last_xfer) begin
            wr_addr_q <= wr_addr_q + ADDR_W'(1);
         end
      end
   end

   assign ram_addr = (state_q == LOAD) ? wr_addr_q : bus.pc;

   inst_ram u_inst_ram (
      .clk   (origclk),
      .we    (xfer),
      .addr  (ram_addr),
      .wdata (bus.load_data),
      .rdata (ram_rdata)
   );

   assign bus.instruction = fetch_vld_q ? ram_rdata : NOP_INST;
   assign bus.cpu_hold    = (state_q != RUN);
   assign bus.load_ready  = (state_q == LOAD);
   assign bus.load_done   = load_done_q;

endmodule

// File: tb/tb_instruction_store.sv
// Directed bench for instruction_store: loads, stalls, full depth, reload and resets.
module tb_instruction_store;
   import cpu_pkg::*;

   logic origclk = 1'b0;
   logic reset   = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   instruction_store_if bus ();

   instruction_store dut (
      .origclk (origclk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 origclk = ~origclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge origclk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      bus.load_valid = 1'b1;
      bus.load_data  = d;
      tick();
      bus.load_valid = 1'b0;
   endtask

   task automatic start_load(input logic [7:0] len);
      bus.load_start = 1'b1;
      bus.load_len   = len;
      tick();
      bus.load_start = 1'b0;
   endtask

   task automatic fetch(input string tag, input logic [7:0] a, input logic [7:0] e);
      bus.pc = a;
      tick();
      chk(tag, bus.instruction, e);
   endtask

   initial begin
      logic [7:0] v;
      bus.pc         = '0;
      bus.load_start = 1'b0;
      bus.load_len   = '0;
      bus.load_data  = '0;
      bus.load_valid = 1'b0;

      #1;
      chk("rst_instruction", bus.instruction, 8'h00);
      chk("rst_cpu_hold", bus.cpu_hold, 1'b1);
      chk("rst_load_ready", bus.load_ready, 1'b0);
      chk("rst_load_done", bus.load_done, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("empty_cpu_hold", bus.cpu_hold, 1'b1);
      chk("empty_load_ready", bus.load_ready, 1'b0);

      // basic load of four bytes
      start_load(8'd3);
      chk("basic_ready", bus.load_ready, 1'b1);
      chk("basic_hold", bus.cpu_hold, 1'b1);
      chk("basic_nop", bus.instruction, 8'h00);
      send(8'hA1);
      chk("basic_done_early0", bus.load_done, 1'b0);
      send(8'hB2);
      send(8'hC3);
      chk("basic_done_early2", bus.load_done, 1'b0);
      send(8'hD4);
      chk("basic_done", bus.load_done, 1'b1);
      chk("basic_hold_fall", bus.cpu_hold, 1'b0);
      chk("basic_ready_fall", bus.load_ready, 1'b0);
      fetch("basic_pc2", 8'd2, 8'hC3);
      chk("basic_done_pulse", bus.load_done, 1'b0);
      fetch("basic_pc0", 8'd0, 8'hA1);
      fetch("basic_pc3", 8'd3, 8'hD4);

      // reload one byte from RUN
      start_load(8'd0);
      chk("reload_hold", bus.cpu_hold, 1'b1);
      chk("reload_nop", bus.instruction, 8'h00);
      send(8'h5E);
      chk("reload_done", bus.load_done, 1'b1);
      fetch("reload_pc0", 8'd0, 8'h5E);
      fetch("reload_pc1", 8'd1, 8'hB2);
      fetch("reload_pc2", 8'd2, 8'hC3);
      fetch("reload_pc3", 8'd3, 8'hD4);

      // two-byte load with a 5-cycle gap
      start_load(8'd1);
      send(8'h11);
      bus.load_data = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_no_done", bus.load_done, 1'b0);
      end
      chk("stall_hold", bus.cpu_hold, 1'b1);
      send(8'h22);
      chk("stall_done", bus.load_done, 1'b1);
      fetch("stall_pc0", 8'd0, 8'h11);
      fetch("stall_pc1", 8'd1, 8'h22);
      fetch("stall_pc2", 8'd2, 8'hC3);

      // full 256-byte load, data = ~addr
      start_load(8'd255);
      for (int i = 0; i < 255; i++) begin
         v = i[7:0];
         send(~v);
      end
      chk("full_done_early", bus.load_done, 1'b0);
      chk("full_hold_early", bus.cpu_hold, 1'b1);
      send(8'h00);
      chk("full_done", bus.load_done, 1'b1);
      chk("full_hold", bus.cpu_hold, 1'b0);
      for (int i = 0; i < 256; i++) begin
         v = i[7:0];
         fetch("full_sweep", v, ~v);
      end

      // reset in the middle of a load, with an ignored start request
      start_load(8'd3);
      send(8'h01);
      bus.load_start = 1'b1;
      bus.load_len   = 8'd0;
      send(8'h02);
      bus.load_start = 1'b0;
      chk("midload_hold", bus.cpu_hold, 1'b1);
      chk("midload_no_done", bus.load_done, 1'b0);
      chk("midload_ready", bus.load_ready, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_hold", bus.cpu_hold, 1'b1);
      chk("midrst_ready", bus.load_ready, 1'b0);
      chk("midrst_nop", bus.instruction, 8'h00);
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("midrst_hold_stays", bus.cpu_hold, 1'b1);
      start_load(8'd0);
      send(8'h77);
      chk("after_rst_done", bus.load_done, 1'b1);
      fetch("after_rst_pc0", 8'd0, 8'h77);
      fetch("after_rst_pc1", 8'd1, 8'h02);
      fetch("after_rst_pc2", 8'd2, 8'hFD);
      fetch("after_rst_pc3", 8'd3, 8'hFC);
      fetch("after_rst_pc4", 8'd4, 8'hFB);

      // asynchronous reset while running
      #2;
      reset = 1'b0;
      #1;
      chk("runrst_nop", bus.instruction, 8'h00);
      chk("runrst_hold", bus.cpu_hold, 1'b1);
      chk("runrst_ready", bus.load_ready, 1'b0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
